// File: rtl/temp_sensor_pkg.sv
// ============================================================================
// temp_sensor_pkg
// Shared FSM state type and default constants for the temperature reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package temp_sensor_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CALC = 3'd3,
        S_BCD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [6:0] c_temp_addr = 7'h00;
    localparam int         c_k_mul     = 40318;
    localparam int         c_k_off     = 2731;
    localparam int         c_bcd_w     = 4;

endpackage

`default_nettype wire

// File: rtl/temp_sensor_bin2bcd_seq.sv
// ============================================================================
// temp_sensor_bin2bcd_seq
// Sequential 12-bit to 4-digit BCD double-dabble, fixed 12-cycle run.
// Revision: 1.0
// ============================================================================
`default_nettype none

module temp_sensor_bin2bcd_seq
    import temp_sensor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [11:0]            bin,
    output logic                   done,
    output logic [4*c_bcd_w-1:0]   bcd
);

    logic [11:0]          r_bin;
    logic [4*c_bcd_w-1:0] r_bcd;
    logic [4*c_bcd_w-1:0] w_adj;
    logic [3:0]           r_cnt;
    logic                 r_busy;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*c_bcd_w +: c_bcd_w] >= 4'd5)
                w_adj[i*c_bcd_w +: c_bcd_w] = r_bcd[i*c_bcd_w +: c_bcd_w] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_cnt  <= 4'd12;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd  <= {w_adj[4*c_bcd_w-2:0], r_bin[11]};
            r_bin  <= {r_bin[10:0], 1'b0};
            r_cnt  <= r_cnt - 4'd1;
            if (r_cnt == 4'd1)
                r_busy <= 1'b0;
        end
    end

    // High during the cycle whose closing edge performs the final shift.
    assign done = r_busy && (r_cnt == 4'd1);
    assign bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/temp_sensor.sv
// ============================================================================
// temp_sensor
// Triggered DRP temperature read, conversion to tenths of degC, BCD output.
// Optional macro TEMP_SENSOR_AVG4_EN: average of the last four raw codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module temp_sensor
    import temp_sensor_pkg::*;
#(
    parameter logic [6:0] TEMP_ADDR = c_temp_addr,
    parameter int         K_MUL     = c_k_mul,
    parameter int         K_OFF     = c_k_off
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] temp_ent_bcd,
    output logic [3:0]  temp_dec_bcd,
    output logic        testigo
);

    state_t      r_state, w_next;
    logic        r_trig_q;
    logic        w_req;
    logic        w_capture;
    logic [11:0] w_code;
    logic [27:0] w_prod;
    logic [12:0] w_p, w_diff;
    logic [11:0] w_t;
    logic        w_bcd_done;
    logic [15:0] w_bcd;

    assign w_req     = trigger && !r_trig_q;
    assign w_capture = (r_state == S_WAIT) && drp_drdy;
    assign drp_daddr = TEMP_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        drp_den = 1'b0;
        case (r_state)
            S_IDLE: if (w_req) w_next = S_REQ;
            S_REQ: begin
                drp_den = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: if (drp_drdy) w_next = S_CALC;
            S_CALC: w_next = S_BCD;
            S_BCD:  if (w_bcd_done) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef TEMP_SENSOR_AVG4_EN
    logic [11:0] r_hist [4];
    logic        r_primed;
    logic [13:0] w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_primed <= 1'b0;
        end else if (w_capture) begin
            // First capture after reset fills the whole history.
            r_hist[0] <= drp_do[15:4];
            for (int i = 1; i < 4; i++)
                r_hist[i] <= r_primed ? r_hist[i-1] : drp_do[15:4];
            r_primed <= 1'b1;
        end
    end

    assign w_sum  = 14'(r_hist[0]) + 14'(r_hist[1]) + 14'(r_hist[2]) + 14'(r_hist[3]);
    assign w_code = w_sum[13:2];
    logic w_unused_avg;
    assign w_unused_avg = &{1'b0, w_sum[1:0]};
`else
    logic [11:0] r_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_code <= '0;
        else if (w_capture) r_code <= drp_do[15:4];
    end

    assign w_code = r_code;
`endif

    assign w_prod = 28'(w_code) * 28'(K_MUL);
    assign w_p    = w_prod[27:15];
    assign w_diff = w_p - 13'(K_OFF);
    assign w_t    = (w_p >= 13'(K_OFF)) ? w_diff[11:0] : 12'd0;

    logic w_unused;
    assign w_unused = &{1'b0, drp_do[3:0], w_prod[14:0], w_diff[12]};

    temp_sensor_bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (r_state == S_CALC),
        .bin   (w_t),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_q     <= 1'b0;
            temp_ent_bcd <= '0;
            temp_dec_bcd <= '0;
            testigo      <= 1'b0;
        end else begin
            r_trig_q <= trigger;
            if (r_state == S_DONE) begin
                temp_ent_bcd <= w_bcd[15:4];
                temp_dec_bcd <= w_bcd[3:0];
                testigo      <= ~testigo;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_temp_sensor.sv
// ============================================================================
// tb_temp_sensor
// Directed-vector bench for temp_sensor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_temp_sensor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic [11:0] temp_ent_bcd;
    logic [3:0]  temp_dec_bcd;
    logic        testigo;

    int n_checks = 0;
    int n_pass   = 0;
    int den_cnt  = 0;

    logic [11:0] m_ent = '0;
    logic [3:0]  m_dec = '0;
    logic        m_tog = 1'b0;

    temp_sensor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .drp_den      (drp_den),
        .drp_daddr    (drp_daddr),
        .drp_do       (drp_do),
        .drp_drdy     (drp_drdy),
        .temp_ent_bcd (temp_ent_bcd),
        .temp_dec_bcd (temp_dec_bcd),
        .testigo      (testigo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (drp_den) den_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_ent = '0; m_dec = '0; m_tog = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Trigger, serve the DRP read with d, then check hold time and result.
    task automatic measure(input logic [15:0] d, input logic [11:0] e_ent,
                           input logic [3:0] e_dec, input bit retrig, input string tag);
        int n;
        int den0;
        bit held;
        den0 = den_cnt;
        @(negedge clk);
        trigger = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drp_den && n < 10);
        check({tag, "_den"}, {31'd0, drp_den}, 32'd1);
        check({tag, "_daddr"}, {25'd0, drp_daddr}, 32'd0);
        @(negedge clk);
        trigger = 1'b0;
        check({tag, "_den_pulse"}, {31'd0, drp_den}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (retrig) trigger = (i == 0);
        end
        drp_do   = d;
        drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        held = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (temp_ent_bcd !== m_ent || temp_dec_bcd !== m_dec || testigo !== m_tog)
                held = 1'b0;
        end
        check({tag, "_hold"}, {31'd0, held}, 32'd1);
        @(negedge clk);
        m_tog = ~m_tog;
        m_ent = e_ent;
        m_dec = e_dec;
        check({tag, "_ent"}, {20'd0, temp_ent_bcd}, {20'd0, e_ent});
        check({tag, "_dec"}, {28'd0, temp_dec_bcd}, {28'd0, e_dec});
        check({tag, "_testigo"}, {31'd0, testigo}, {31'd0, m_tog});
        repeat (6) @(negedge clk);
        check({tag, "_den_count"}, den_cnt - den0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int den0;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ent", {20'd0, temp_ent_bcd}, 32'd0);
        check("rst_dec", {28'd0, temp_dec_bcd}, 32'd0);
        check("rst_testigo", {31'd0, testigo}, 32'd0);
        check("rst_den", {31'd0, drp_den}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_no_den", den_cnt, 32'd0);

        measure(16'hA000, 12'h041, 4'h8, 1'b0, "a00");

        // Spurious drdy in IDLE, then a retriggered-in-WAIT measurement
        do_reset();
        den0 = den_cnt;
        drp_do   = 16'hFFF0;
        drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        repeat (20) @(negedge clk);
        check("spur_ent", {20'd0, temp_ent_bcd}, 32'd0);
        check("spur_testigo", {31'd0, testigo}, 32'd0);
        check("spur_den", den_cnt - den0, 32'd0);
        measure(16'hA000, 12'h041, 4'h8, 1'b1, "retrig");

        do_reset();
        measure(16'h8000, 12'h000, 4'h0, 1'b0, "clamp");

        do_reset();
        measure(16'hFFF0, 12'h230, 4'h7, 1'b0, "fff");

        // Reset while in BCD conversion
        @(negedge clk);
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        drp_do   = 16'h9E00;
        drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        m_ent = '0; m_dec = '0; m_tog = 1'b0;
        #1;
        check("midrst_ent", {20'd0, temp_ent_bcd}, 32'd0);
        check("midrst_dec", {28'd0, temp_dec_bcd}, 32'd0);
        check("midrst_den", {31'd0, drp_den}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_idle", {20'd0, temp_ent_bcd}, 32'd0);
        measure(16'h9E00, 12'h037, 4'h9, 1'b0, "9e0");

        do_reset();
        measure(16'hA000, 12'h041, 4'h8, 1'b0, "seq1");
        measure(16'hA000, 12'h041, 4'h8, 1'b0, "seq2");
        measure(16'hA000, 12'h041, 4'h8, 1'b0, "seq3");
`ifdef TEMP_SENSOR_AVG4_EN
        measure(16'hA400, 12'h043, 4'h8, 1'b0, "seq4_avg");
`else
        measure(16'hA400, 12'h049, 4'h7, 1'b0, "seq4");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
